// File: rtl/fwd_unit.sv
// Forwarding and load-use hazard unit: tracks a shadow copy of the EX..WB
// destination registers and produces registered operand selects plus a stall.
module fwd_unit #(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16,
  localparam int FW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  // The WB stage is never compared, so only stages 1..DEPTH-1 are stored;
  // MemRead only matters for the instruction in EX.
  logic [DEPTH-1:1][REG_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:1]            wr_q, wr_d;
  logic                        mr_q, mr_d;
  logic [FW-1:0]               fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [FW-1:0] code_a, code_b;
  logic          hit_a1, hit_b1;

  always_comb begin
    code_a = '0;
    code_b = '0;
    // Scan oldest to youngest so the youngest match overwrites.
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (wr_q[j] && (rd_q[j] == id_rn) && (id_rn != ZERO_IDX)) code_a = FW'(j);
      if (wr_q[j] && (rd_q[j] == id_rm) && (id_rm != ZERO_IDX)) code_b = FW'(j);
    end
    hit_a1 = wr_q[1] && (rd_q[1] == id_rn) && (id_rn != ZERO_IDX);
    hit_b1 = wr_q[1] && (rd_q[1] == id_rm) && (id_rm != ZERO_IDX);
    stall  = en && !flush && mr_q && (hit_a1 || hit_b1);
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    mr_d    = mr_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (en) begin
      for (int k = DEPTH - 1; k >= 2; k--) begin
        rd_d[k] = rd_q[k-1];
        wr_d[k] = wr_q[k-1];
      end
      if (flush || stall) begin
        rd_d[1] = '0;
        wr_d[1] = 1'b0;
        mr_d    = 1'b0;
        fwd_a_d = '0;
        fwd_b_d = '0;
      end else begin
        rd_d[1] = id_rd;
        wr_d[1] = id_regwrite;
        mr_d    = id_memread;
        fwd_a_d = code_a;
        fwd_b_d = code_b;
      end
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      mr_q    <= 1'b0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mr_q    <= mr_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/fwd_unit.md
# fwd_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It holds its own shadow pipeline of destination register, RegWrite and MemRead for the instructions between EX and WB. Each cycle it compares the decode-stage source registers against that shadow pipeline. It registers per-operand forwarding selects so they are aligned with the instruction when it enters EX, and it raises a load-use stall. It replaces the per-pair 5-bit match comparators.

## Interface
- REG_W, 5: register index width.
- DEPTH, 3: tracked stages after decode (1=EX, 2=MEM, …, DEPTH=WB); minimum 2.
- ZERO_REG, 31: hard-wired zero register index; never forwarded, never stalls.
- CNT_W, 16: stall counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; 0 freezes all state.
- flush  in  1  replace the instruction entering EX with a bubble.
- id_rd  in  REG_W  decode-stage destination register.
- id_regwrite  in  1  decode-stage RegWrite.
- id_memread  in  1  decode-stage MemRead (load).
- id_rn  in  REG_W  decode-stage source A.
- id_rm  in  REG_W  decode-stage source B.
- fwd_a  out  FW=$clog2(DEPTH)  registered operand-A select, valid while the instruction is in EX.
- fwd_b  out  FW  registered operand-B select.
- stall  out  1  combinational load-use stall request.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Shadow stage s[k], k=1..DEPTH, each {rd, wr, mr}. s[1] is the instruction now in EX.
- Match for source x against stage k: s[k].wr & (s[k].rd == x) & (x != ZERO_REG).
- Forward select code j (1..DEPTH-1) means "take the result of stage j+1 when this instruction is in EX". Code 0 means register file.
- Code j is produced by a match against s[j]. The youngest match wins, so the lowest j has priority.
- s[DEPTH] is never compared. The register file gives write-before-read for WB.
- Load-use: stall = en & ~flush & s[1].mr & s[1].wr & (match(id_rn,1) | match(id_rm,1)).
- On clk rising with en=1:
  - s[k] <= s[k-1] for k=2..DEPTH.
  - If flush or stall, then s[1] <= bubble {0,0,0} and fwd_a/fwd_b <= 0.
  - Otherwise s[1] <= {id_rd, id_regwrite, id_memread}, and fwd_a/fwd_b <= the computed codes.
- When stall is asserted, the CPU holds IF/ID. The block re-evaluates the same decode instruction the next cycle, when the load is in s[2].
- stall_cnt increments on each clock with en=1 and stall=1, and saturates at 2^CNT_W-1.
- flush together with a stall condition: flush wins. stall=0, a bubble is inserted, and the counter does not increment.
- en=0: all registers hold and stall=0.

## Timing
- Reset (asynchronous, active-low): all s[k] fields 0, fwd_a=fwd_b=0, stall_cnt=0. stall=0 as a consequence.
- fwd_* has 1-cycle latency from the decode-stage inputs, updating on the edge that moves the instruction into EX.
- stall has zero-cycle (combinational) latency from id_rn/id_rm and s[1].
- A load-use hazard costs exactly 1 stall cycle, after which the select is code 2 (WB) for DEPTH=3.
- Reset asserted mid-stream clears the shadow pipeline immediately. The first post-reset decode instruction sees no matches.

## Test plan
- Reset, then ADD X3 decoded followed by SUB using Rn=X3 -> the SUB instruction enters EX with fwd_a=1, fwd_b=0, stall=0.
- Write X5 then an unrelated instruction, then read X5 on Rm -> fwd_b=2. Writes to X5 in both s[1] and s[2] -> fwd_b=1 (youngest wins).
- LDUR X7 then ADD using Rn=X7 -> stall=1 for exactly one cycle and stall_cnt=1. The ADD then enters EX with fwd_a=2.
- A write to X31 (ZERO_REG) followed by a read of X31 -> fwd_a=fwd_b=0 and stall=0, including when the producer is a load.
- A load-use condition with flush=1 -> stall=0, a bubble in s[1], and stall_cnt unchanged. With en=0 held for 3 cycles, all outputs and stall_cnt hold.
- Preload the counter near saturation (CNT_W=4 build, 17 stall cycles) -> stall_cnt=15. Async reset asserted mid-cycle -> all outputs 0 before the next edge.
